// File: rtl/crypt_pkg.sv
// Shared types and constants for the 16-bit permutation encryption co-processor.
package crypt_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    R1   = 2'd1,
    R2   = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    E1 = 2'd0,
    E2 = 2'd1,
    D1 = 2'd2,
    D2 = 2'd3
  } round_sel_t;

  // Round applied while the job sits in R1/R2; decrypt runs the inverses in reverse order.
  function automatic round_sel_t round_for(input state_t st, input logic decrypt);
    if (st == R1) return decrypt ? D2 : E1;
    return decrypt ? D1 : E2;
  endfunction

endpackage

// File: rtl/crypt_perm_round.sv
// One permutation round: selects one of the four fixed 16-bit bit permutations.
module crypt_perm_round
  import crypt_pkg::*;
(
  input  round_sel_t          sel,
  input  logic [DATA_W-1:0]   in,
  output logic [DATA_W-1:0]   out
);

  always_comb begin
    // NOTE: default assignment before the case so every path drives out and no latch is inferred.
    out = in;
    case (sel)
      E1: out = {in[15], in[10], in[5],  in[0],  in[14], in[9],  in[4],  in[11],
                 in[13], in[8],  in[3],  in[12], in[7],  in[2],  in[1],  in[6]};
      E2: out = {in[0],  in[2],  in[4],  in[6],  in[8],  in[10], in[12], in[14],
                 in[1],  in[3],  in[5],  in[7],  in[9],  in[11], in[13], in[15]};
      D2: out = {in[0],  in[8],  in[1],  in[9],  in[2],  in[10], in[3],  in[11],
                 in[4],  in[12], in[5],  in[13], in[6],  in[14], in[7],  in[15]};
      D1: out = {in[15], in[11], in[7],  in[4],  in[8],  in[14], in[10], in[6],
                 in[3],  in[0],  in[13], in[9],  in[5],  in[2],  in[1],  in[12]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/crypt_job_scheduler.sv
// Round-robin job scheduler and two-round sequencer for the permutation co-processor.
module crypt_job_scheduler
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_mode,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_mode,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tag,
  output logic              busy,
  output logic [7:0]        done_count
);

  state_t            state;
  logic [DATA_W-1:0] work_reg;
  logic [DATA_W-1:0] round_out;
  logic              tag_reg;
  logic              mode_reg;
  logic              last_served;
  logic              grant0;
  logic              grant1;
  round_sel_t        round_sel;

  // On a tie the requester that was not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_served);
  assign grant1 = req1_valid & (~req0_valid | ~last_served);

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_data  = work_reg;
  assign out_tag   = tag_reg;

  assign round_sel = round_for(state, mode_reg);

  crypt_perm_round u_round (
    .sel (round_sel),
    .in  (work_reg),
    .out (round_out)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      work_reg    <= '0;
      tag_reg     <= 1'b0;
      mode_reg    <= 1'b0;
      last_served <= 1'b1;
      done_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            work_reg <= req1_ready ? req1_data : req0_data;
            mode_reg <= req1_ready ? req1_mode : req0_mode;
            tag_reg  <= req1_ready;
            state    <= R1;
          end
        end
        R1: begin
          work_reg <= round_out;
          state    <= R2;
        end
        R2: begin
          work_reg <= round_out;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            done_count  <= done_count + 8'd1;
            last_served <= tag_reg;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypt_job_scheduler.sv
// Self-checking bench: directed vectors plus randomized traffic against a job-level reference model.
module tb_crypt_job_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0v = 1'b0, r0m = 1'b0, r1v = 1'b0, r1m = 1'b0, ordy = 1'b0;
  logic [15:0] r0d = '0, r1d = '0;
  logic        req0_ready, req1_ready, out_valid, out_tag, busy;
  logic [15:0] out_data;
  logic [7:0]  done_count;

  always #5 clk = ~clk;

  crypt_job_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (r0v),
    .req0_mode  (r0m),
    .req0_data  (r0d),
    .req0_ready (req0_ready),
    .req1_valid (r1v),
    .req1_mode  (r1m),
    .req1_data  (r1d),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (ordy),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy),
    .done_count (done_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-source tables, listed from out[15] down to out[0]: 0=E1 1=E2 2=D2 3=D1.
  int maps[4][16] = '{
    '{15, 10, 5, 0, 14, 9, 4, 11, 13, 8, 3, 12, 7, 2, 1, 6},
    '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3, 5, 7, 9, 11, 13, 15},
    '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15},
    '{15, 11, 7, 4, 8, 14, 10, 6, 3, 0, 13, 9, 5, 2, 1, 12}
  };

  function automatic logic [15:0] permute(input int m, input logic [15:0] x);
    logic [15:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[15-k] = x[maps[m][k]];
    return y;
  endfunction

  function automatic logic [15:0] job_result(input logic mode, input logic [15:0] x);
    return mode ? permute(3, permute(2, x)) : permute(1, permute(0, x));
  endfunction

  // Job-level model: at most one job in flight, result offered from the third cycle after accept.
  bit          m_busy, m_tag, m_last;
  int          m_acc;
  logic [15:0] m_res;
  logic [7:0]  m_done;
  int          cyc = 0;
  bit          a0, a1;
  bit          v_seen;
  int          v_cyc;
  logic [15:0] v_data;
  logic        v_tag;
  int          dut_grants[$];

  task automatic model_reset();
    m_busy = 0; m_tag = 0; m_last = 1; m_acc = 0; m_res = '0; m_done = 8'd0;
    a0 = 0; a1 = 0;
  endtask

  // One clock cycle: sample and compare on the falling edge, advance the model, cross the rising edge.
  task automatic tick();
    bit g0, g1, exp_v;
    @(negedge clk);
    g0 = 0; g1 = 0;
    if (!m_busy) begin
      if (r0v && r1v) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = r0v;
        g1 = r1v;
      end
    end
    exp_v = m_busy && (cyc - m_acc >= 3);
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    check("one_ready", req0_ready & req1_ready, 0);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, exp_v);
    check("done_count", done_count, m_done);
    if (exp_v) begin
      check("out_data", out_data, m_res);
      check("out_tag", out_tag, m_tag);
    end
    if (out_valid && !v_seen) begin
      v_seen = 1; v_cyc = cyc; v_data = out_data; v_tag = out_tag;
    end
    if (req0_ready && r0v) dut_grants.push_back(0);
    if (req1_ready && r1v) dut_grants.push_back(1);
    a0 = g0; a1 = g1;
    if (g0 || g1) begin
      m_busy = 1; m_acc = cyc; m_tag = g1;
      m_res  = g1 ? job_result(r1m, r1d) : job_result(r0m, r0d);
      v_seen = 0; v_cyc = -100;
    end else if (exp_v && ordy) begin
      m_busy = 0; m_done = m_done + 8'd1; m_last = m_tag;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r0v = 0; r1v = 0; ordy = 0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_tag", out_tag, 0);
    check("rst_done_count", done_count, 0);
    reset = 1'b0;
  endtask

  task automatic run_job(input int k, input logic mode, input logic [15:0] data,
                         input logic [15:0] exp);
    ordy = 1;
    if (k == 0) begin r0v = 1; r0m = mode; r0d = data; end
    else        begin r1v = 1; r1m = mode; r1d = data; end
    a0 = 0; a1 = 0;
    for (int i = 0; i < 8 && !(k == 0 ? a0 : a1); i++) tick();
    check("job_accept", (k == 0) ? a0 : a1, 1);
    r0v = 0; r1v = 0;
    for (int i = 0; i < 8 && m_busy; i++) tick();
    check("job_latency", v_cyc - m_acc, 3);
    check("job_data", v_data, exp);
    check("job_tag", v_tag, k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p0, p1;
    do_reset();

    // Directed vectors with hand-derived results.
    run_job(0, 0, 16'h0001, 16'h0200);
    check("done_after_first", done_count, 1);
    run_job(1, 1, 16'h0200, 16'h0001);
    run_job(0, 0, 16'h8000, 16'h0001);
    run_job(1, 1, 16'h0001, 16'h8000);
    run_job(0, 0, 16'hFFFF, 16'hFFFF);
    run_job(1, 1, 16'hFFFF, 16'hFFFF);
    run_job(0, 0, 16'h0000, 16'h0000);
    run_job(1, 1, 16'h0000, 16'h0000);

    // Both requesters valid from reset: alternation starting with requester 0.
    do_reset();
    dut_grants.delete();
    r0v = 1; r1v = 1; ordy = 1;
    r0m = 1'($urandom_range(0, 1)); r0d = 16'($urandom);
    r1m = 1'($urandom_range(0, 1)); r1d = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (a0) r0d = 16'($urandom);
      if (a1) r1d = 16'($urandom);
    end
    check("arb_count", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++)
      check("arb_order", (i < dut_grants.size()) ? dut_grants[i] : 9, i % 2);

    // Backpressure: result held for 10 cycles with both requesters pending.
    ordy = 0;
    for (int i = 0; i < 10 && !(m_busy && (cyc - m_acc >= 3)); i++) begin
      tick();
      if (a0) r0d = 16'($urandom);
      if (a1) r1d = 16'($urandom);
    end
    check("bp_reached_out", out_valid, 1);
    for (int i = 0; i < 10; i++) tick();
    ordy = 1;
    tick();
    check("bp_idle_after_release", busy, 0);
    r0v = 0; r1v = 0;
    for (int i = 0; i < 8 && m_busy; i++) tick();

    // Randomized traffic with legal valid drops and random backpressure.
    p0 = 0; p1 = 0; a0 = 0; a1 = 0;
    for (int i = 0; i < 2000; i++) begin
      if (a0) p0 = 0;
      else if (p0 && $urandom_range(0, 31) == 0) p0 = 0;
      else if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; r0m = 1'($urandom_range(0, 1)); r0d = 16'($urandom);
      end
      if (a1) p1 = 0;
      else if (p1 && $urandom_range(0, 31) == 0) p1 = 0;
      else if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; r1m = 1'($urandom_range(0, 1)); r1d = 16'($urandom);
      end
      r0v = p0; r1v = p1;
      ordy = ($urandom_range(0, 3) != 0);
      tick();
    end
    r0v = 0; r1v = 0; ordy = 1;
    for (int i = 0; i < 8 && m_busy; i++) tick();

    // Reset asserted while the job is in R2.
    do_reset();
    r0v = 1; r0m = 0; r0d = 16'h1234; ordy = 1;
    tick();
    check("r2_accept", a0, 1);
    r0v = 0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("r2rst_out_valid", out_valid, 0);
    check("r2rst_busy", busy, 0);
    check("r2rst_out_data", out_data, 16'h0000);
    check("r2rst_out_tag", out_tag, 0);
    check("r2rst_done_count", done_count, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r2rst_hold_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    r0v = 1; r0d = 16'h0001; r0m = 0;
    tick();
    check("post_rst_accept", a0, 1);
    r0v = 0;
    for (int i = 0; i < 8 && m_busy; i++) tick();
    check("post_rst_done", done_count, 1);

    // 256 back-to-back jobs wrap the completion counter.
    do_reset();
    r0v = 1; r0m = 1'($urandom_range(0, 1)); r0d = 16'($urandom); ordy = 1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (a0) begin r0m = 1'($urandom_range(0, 1)); r0d = 16'($urandom); end
      if (i == 1019) check("wrap_255", done_count, 8'd255);
    end
    check("wrap_zero", done_count, 8'd0);
    r0v = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
